hilo_md_unit: RTL and testbench
===============================

Name: hilo_md_unit

Overview:
- EX-stage multiply/divide controller and HI/LO register file for the five-stage MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and drives the iterative divider through its div/complete handshake.
- Holds operands stable for the whole divide, stalls the pipeline, and writes quotient to LO and remainder to HI.
- Provides HI/LO to EX for MFHI/MFLO.

Parameters:
- DIV_TIMEOUT, 40, max cycles in DIV_WAIT before watchdog abort (must exceed divider latency 34).

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- md_valid  in  1  EX holds a valid HI/LO-class instruction
- md_op  in  3  operation code (package enum)
- md_a  in  32  rs operand
- md_b  in  32  rt operand
- md_flush  in  1  exception/flush from later stage; cancels current op
- md_stall  out  1  freeze IF/ID/EX this cycle
- hi_out  out  32  architectural HI
- lo_out  out  32  architectural LO
- md_err  out  1  one-cycle pulse on watchdog abort
- div_req  out  1  to divider "div"
- div_signed  out  1  to divider
- div_x  out  32  dividend to divider
- div_y  out  32  divisor to divider
- div_s  in  32  quotient from divider
- div_r  in  32  remainder from divider
- div_complete  in  1  divider "complete"

Behaviour:
- Reset (async, resetn=0): state IDLE, HI=LO=0, operand latches 0, md_stall=0, md_err=0, div_req=0, div_signed=0.
- States: IDLE, MUL_WB, DIV_WAIT.
- Issue occurs only in IDLE when md_valid=1 and md_flush=0; md_valid is ignored in every other state.
- MTHI/MTLO: HI (or LO) <= md_a at the issue edge; no stall.
- MULT/MULTU:
  - Issue cycle: md_stall=1; the 64-bit product of md_a, md_b (signed or unsigned) is registered; next state MUL_WB.
  - MUL_WB: HI <= prod[63:32], LO <= prod[31:0] at the edge; md_stall=0; next state IDLE.
  - md_flush in MUL_WB: no write; next state IDLE.
- DIV/DIVU:
  - Issue cycle: latch md_a→div_x, md_b→div_y, signedness→div_signed; md_stall=1; next state DIV_WAIT.
  - div_req = (state==DIV_WAIT), registered; div_x/div_y/div_signed are held constant throughout DIV_WAIT.
  - DIV_WAIT with div_complete=0: md_stall=1.
  - Complete cycle (div_complete=1): md_stall=0; LO <= div_s and HI <= div_r at the edge; next state IDLE, so div_req=0 in the following cycle and the divider does not restart.
  - Nominal stall: issue cycle plus 33 DIV_WAIT cycles = 34 stalled cycles; complete cycle unstalled.
- Divide by zero: no trap. HI/LO take whatever the divider returns.
- md_flush during DIV_WAIT, including the complete cycle: flush wins. No HI/LO write; next state IDLE; div_req drops next cycle, which resets the divider count.
- Watchdog:
  - Counter cleared on entry to DIV_WAIT, increments each DIV_WAIT cycle.
  - When it reaches DIV_TIMEOUT without complete: md_err pulses 1 cycle, no write, next state IDLE.
- hi_out/lo_out are direct register outputs. A write at edge N is visible in cycle N+1, i.e. to the instruction that follows in EX; no extra bypass.
- Only one operation can be in flight; there is no queueing.

Decomposition:
- Shared package hilo_md_pkg:
  - md_op enum: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5, others reserved and treated as no-op.
  - State enum.
  - DIV_NOMINAL_CYCLES=34 constant.
- One sub-module: hilo_regs (HI/LO pair with independent/joint write enables).
- The divider stays external, instantiated beside this unit in EX.

Test Plan:
- DIVU: md_a=100, md_b=7 with a divider model → md_stall high exactly 34 cycles; then LO=14, HI=2; div_req low the cycle after complete.
- DIV signed: md_a=-100 (0xFFFFFF9C), md_b=7 → LO=0xFFFFFFF2 (-14), HI=0xFFFFFFFE (-2); div_signed=1 held throughout.
- MULT: md_a=0xFFFFFFFF, md_b=2 → one stall cycle; HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands → HI=1, LO=0xFFFFFFFE.
- MTHI 0xDEADBEEF then MFHI next cycle → hi_out=0xDEADBEEF with no stall; LO unchanged.
- Flush at DIV_WAIT cycle 10, and separately in the complete cycle → HI/LO keep prior values, state IDLE, md_stall low next cycle, a subsequent DIVU 9/3 gives LO=3, HI=0.
- Divider model that never completes → md_err pulse after 40 DIV_WAIT cycles; HI/LO unchanged; asynchronous resetn mid-divide → all outputs return to reset values immediately.

Source files
------------

// File: rtl/hilo_md_pkg.sv
// Shared types for the EX-stage multiply/divide controller and its HI/LO register pair.
package hilo_md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WB   = 2'd1,
    ST_DIV_WAIT = 2'd2
  } md_state_e;

  localparam int DIV_NOMINAL_CYCLES = 34;

  // Widen a 32-bit operand to 64 bits so one unsigned multiplier serves MULT and MULTU.
  function automatic logic [63:0] ext32(input logic [31:0] v, input logic sgn);
    return {{32{sgn & v[31]}}, v};
  endfunction

endpackage

// File: rtl/hilo_md_unit_hilo_regs.sv
// Architectural HI/LO pair with independent write enables; both may be written together.
module hilo_regs (
  input  logic        clk,
  input  logic        resetn,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hi_d,
  input  logic [31:0] lo_d,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we) hi_q <= hi_d;
      if (lo_we) lo_q <= lo_d;
    end
  end

endmodule

// File: rtl/hilo_md_unit.sv
// EX-stage multiply/divide controller: issues MULT/DIV/MTHI/MTLO, drives the external
// iterative divider, stalls the pipeline and writes results into the HI/LO pair.
module hilo_md_unit
  import hilo_md_pkg::*;
#(
  parameter int DIV_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        md_valid,
  input  logic [2:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  input  logic        md_flush,
  output logic        md_stall,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        md_err,
  output logic        div_req,
  output logic        div_signed,
  output logic [31:0] div_x,
  output logic [31:0] div_y,
  input  logic [31:0] div_s,
  input  logic [31:0] div_r,
  input  logic        div_complete
);

  localparam int WdW = $clog2(DIV_TIMEOUT + 1);

  md_state_e      state, next_state;
  md_op_e         op;
  logic           issue, is_mul, is_div, wd_expire;
  logic [63:0]    prod;
  logic [WdW-1:0] wd_cnt;
  logic           hi_we, lo_we;
  logic [31:0]    hi_d, lo_d;

  assign op     = md_op_e'(md_op);
  assign issue  = (state == ST_IDLE) && md_valid && !md_flush;
  assign is_mul = (op == MD_MULT) || (op == MD_MULTU);
  assign is_div = (op == MD_DIV) || (op == MD_DIVU);
  // Abort in the last permitted wait cycle; a flush or a late complete takes precedence.
  assign wd_expire = (state == ST_DIV_WAIT) && !div_complete && !md_flush &&
                     (wd_cnt == WdW'(DIV_TIMEOUT - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (issue && is_mul)      next_state = ST_MUL_WB;
        else if (issue && is_div) next_state = ST_DIV_WAIT;
      end
      ST_MUL_WB:   next_state = ST_IDLE;
      ST_DIV_WAIT: if (md_flush || div_complete || wd_expire) next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    md_stall = 1'b0;
    hi_we    = 1'b0;
    lo_we    = 1'b0;
    hi_d     = md_a;
    lo_d     = md_a;
    case (state)
      ST_IDLE: begin
        md_stall = issue && (is_mul || is_div);
        hi_we    = issue && (op == MD_MTHI);
        lo_we    = issue && (op == MD_MTLO);
      end
      ST_MUL_WB: begin
        hi_we = !md_flush;
        lo_we = !md_flush;
        hi_d  = prod[63:32];
        lo_d  = prod[31:0];
      end
      ST_DIV_WAIT: begin
        md_stall = !div_complete;
        hi_we    = div_complete && !md_flush;
        lo_we    = div_complete && !md_flush;
        hi_d     = div_r;
        lo_d     = div_s;
      end
      default: ;
    endcase
  end

  // Operands stay frozen for the whole divide; div_req tracks the registered state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prod       <= '0;
      div_x      <= '0;
      div_y      <= '0;
      div_signed <= 1'b0;
      div_req    <= 1'b0;
      md_err     <= 1'b0;
      wd_cnt     <= '0;
    end else begin
      div_req <= (next_state == ST_DIV_WAIT);
      md_err  <= wd_expire;
      if (issue && is_mul)
        prod <= ext32(md_a, op == MD_MULT) * ext32(md_b, op == MD_MULT);
      if (issue && is_div) begin
        div_x      <= md_a;
        div_y      <= md_b;
        div_signed <= (op == MD_DIV);
        wd_cnt     <= '0;
      end else if (state == ST_DIV_WAIT) begin
        wd_cnt <= wd_cnt + WdW'(1);
      end
    end
  end

  hilo_regs u_regs (
    .clk    (clk),
    .resetn (resetn),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .hi_d   (hi_d),
    .lo_d   (lo_d),
    .hi_q   (hi_out),
    .lo_q   (lo_out)
  );

endmodule

// File: tb/tb_hilo_md_unit.sv
// Directed bench for hilo_md_unit with a behavioural 34-cycle divider beside it.
module tb_hilo_md_unit;
  import hilo_md_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        md_valid, md_flush;
  logic [2:0]  md_op;
  logic [31:0] md_a, md_b;
  logic        md_stall, md_err, div_req, div_signed, div_complete;
  logic [31:0] hi_out, lo_out, div_x, div_y, div_s, div_r;

  int checks = 0;
  int errors = 0;

  logic never_complete = 1'b0;
  int   dcnt;

  always #5 clk = ~clk;

  hilo_md_unit #(.DIV_TIMEOUT(40)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .md_valid     (md_valid),
    .md_op        (md_op),
    .md_a         (md_a),
    .md_b         (md_b),
    .md_flush     (md_flush),
    .md_stall     (md_stall),
    .hi_out       (hi_out),
    .lo_out       (lo_out),
    .md_err       (md_err),
    .div_req      (div_req),
    .div_signed   (div_signed),
    .div_x        (div_x),
    .div_y        (div_y),
    .div_s        (div_s),
    .div_r        (div_r),
    .div_complete (div_complete)
  );

  // Divider model: completes in its 34th consecutive cycle of div_req; dropping div_req restarts it.
  always @(posedge clk or negedge resetn) begin
    if (!resetn)      dcnt <= 0;
    else if (div_req) dcnt <= dcnt + 1;
    else              dcnt <= 0;
  end
  assign div_complete = div_req && !never_complete && (dcnt == 33);

  always_comb begin
    div_s = '1;
    div_r = div_x;
    if (div_y != 0) begin
      if (div_signed) begin
        div_s = $signed(div_x) / $signed(div_y);
        div_r = $signed(div_x) % $signed(div_y);
      end else begin
        div_s = div_x / div_y;
        div_r = div_x % div_y;
      end
    end
  end

  task automatic issue_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md_valid = 1'b1;
    md_op    = op;
    md_a     = a;
    md_b     = b;
    #1;
  endtask

  // Issue a divide, count stalled cycles up to the complete cycle, then step into IDLE.
  task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int stalls);
    issue_op(op, a, b);
    stalls = 0;
    while (md_stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
      md_valid = 1'b0;
      #1;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn   = 1'b0;
    md_valid = 1'b0;
    md_flush = 1'b0;
    md_op    = MD_MULT;
    md_a     = '0;
    md_b     = '0;
    #1;
    checks++;
    if (md_stall !== 1'b0 || div_req !== 1'b0 || md_err !== 1'b0 || div_signed !== 1'b0) begin
      $display("[TB] FAIL reset_ctrl: stall=%b req=%b err=%b sgn=%b, expected all 0",
               md_stall, div_req, md_err, div_signed);
      errors++;
    end
    checks++;
    if (hi_out !== 32'h0 || lo_out !== 32'h0 || div_x !== 32'h0 || div_y !== 32'h0) begin
      $display("[TB] FAIL reset_regs: hi=%h lo=%h x=%h y=%h, expected all 0",
               hi_out, lo_out, div_x, div_y);
      errors++;
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_mtx();
    issue_op(MD_MTLO, 32'h12345678, 32'h0);
    checks++;
    if (md_stall !== 1'b0) begin
      $display("[TB] FAIL mtlo_stall: got %b expected 0", md_stall);
      errors++;
    end
    issue_op(MD_MTHI, 32'hDEADBEEF, 32'h0);
    checks++;
    if (md_stall !== 1'b0 || lo_out !== 32'h12345678) begin
      $display("[TB] FAIL mthi_issue: stall=%b lo=%h, expected 0 / 12345678", md_stall, lo_out);
      errors++;
    end
    @(negedge clk);
    md_valid = 1'b0;
    #1;
    checks++;
    if (hi_out !== 32'hDEADBEEF || lo_out !== 32'h12345678) begin
      $display("[TB] FAIL mfhi_read: hi=%h lo=%h, expected deadbeef / 12345678", hi_out, lo_out);
      errors++;
    end
  endtask

  task automatic test_mult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue_op(op, a, b);
    checks++;
    if (md_stall !== 1'b1) begin
      $display("[TB] FAIL mult_issue_stall op%0d: got %b expected 1", op, md_stall);
      errors++;
    end
    @(negedge clk);
    md_valid = 1'b0;
    #1;
    checks++;
    if (md_stall !== 1'b0) begin
      $display("[TB] FAIL mult_wb_stall op%0d: got %b expected 0", op, md_stall);
      errors++;
    end
    @(negedge clk);
    #1;
    checks++;
    if (hi_out !== exp_hi || lo_out !== exp_lo) begin
      $display("[TB] FAIL mult_result op%0d: hi=%h lo=%h, expected %h / %h",
               op, hi_out, lo_out, exp_hi, exp_lo);
      errors++;
    end
  endtask

  task automatic test_mult_flush();
    issue_op(MD_MULTU, 32'd3, 32'd4);
    @(negedge clk);
    md_valid = 1'b0;
    md_flush = 1'b1;
    @(negedge clk);
    md_flush = 1'b0;
    #1;
    checks++;
    if (hi_out !== 32'h1 || lo_out !== 32'hFFFFFFFE || md_stall !== 1'b0) begin
      $display("[TB] FAIL mult_flush: hi=%h lo=%h stall=%b, expected 1 / fffffffe / 0",
               hi_out, lo_out, md_stall);
      errors++;
    end
  endtask

  task automatic test_divu();
    int stalls;
    run_div(MD_DIVU, 32'd100, 32'd7, stalls);
    checks++;
    if (stalls !== 34) begin
      $display("[TB] FAIL divu_stall_cycles: got %0d expected 34", stalls);
      errors++;
    end
    checks++;
    if (lo_out !== 32'd14 || hi_out !== 32'd2) begin
      $display("[TB] FAIL divu_result: lo=%h hi=%h, expected 0000000e / 00000002", lo_out, hi_out);
      errors++;
    end
    checks++;
    if (div_req !== 1'b0) begin
      $display("[TB] FAIL divu_req_drop: got %b expected 0", div_req);
      errors++;
    end
    @(negedge clk);
    #1;
    checks++;
    if (div_req !== 1'b0 || md_stall !== 1'b0) begin
      $display("[TB] FAIL divu_no_restart: req=%b stall=%b, expected 0 / 0", div_req, md_stall);
      errors++;
    end
  endtask

  task automatic test_div_signed();
    int stalls = 0;
    int held_bad = 0;
    issue_op(MD_DIV, 32'hFFFFFF9C, 32'd7);
    while (md_stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
      #1;
      if (div_signed !== 1'b1 || div_x !== 32'hFFFFFF9C || div_y !== 32'd7) held_bad++;
    end
    @(negedge clk);
    md_valid = 1'b0;
    #1;
    checks++;
    if (stalls !== 34 || held_bad !== 0) begin
      $display("[TB] FAIL div_signed_hold: stalls=%0d bad_cycles=%0d, expected 34 / 0",
               stalls, held_bad);
      errors++;
    end
    checks++;
    if (lo_out !== 32'hFFFFFFF2 || hi_out !== 32'hFFFFFFFE) begin
      $display("[TB] FAIL div_signed_result: lo=%h hi=%h, expected fffffff2 / fffffffe",
               lo_out, hi_out);
      errors++;
    end
  endtask

  task automatic test_after_flush_divu(input string tag);
    int stalls;
    run_div(MD_DIVU, 32'd9, 32'd3, stalls);
    checks++;
    if (stalls !== 34 || lo_out !== 32'd3 || hi_out !== 32'd0) begin
      $display("[TB] FAIL %s_redo: stalls=%0d lo=%h hi=%h, expected 34 / 3 / 0",
               tag, stalls, lo_out, hi_out);
      errors++;
    end
  endtask

  task automatic test_flush_wait();
    issue_op(MD_MTHI, 32'hAAAA5555, 32'h0);
    issue_op(MD_MTLO, 32'h0F0F0F0F, 32'h0);
    issue_op(MD_DIVU, 32'd50, 32'd5);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      md_valid = 1'b0;
      if (i == 10) md_flush = 1'b1;
    end
    @(negedge clk);
    md_flush = 1'b0;
    #1;
    checks++;
    if (hi_out !== 32'hAAAA5555 || lo_out !== 32'h0F0F0F0F ||
        md_stall !== 1'b0 || div_req !== 1'b0) begin
      $display("[TB] FAIL flush_wait: hi=%h lo=%h stall=%b req=%b, expected aaaa5555 / 0f0f0f0f / 0 / 0",
               hi_out, lo_out, md_stall, div_req);
      errors++;
    end
    test_after_flush_divu("flush_wait");
  endtask

  task automatic test_flush_complete();
    int stalls = 0;
    issue_op(MD_MTHI, 32'h11111111, 32'h0);
    issue_op(MD_MTLO, 32'h22222222, 32'h0);
    issue_op(MD_DIVU, 32'd77, 32'd7);
    while (md_stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
      md_valid = 1'b0;
      #1;
    end
    md_flush = 1'b1;
    @(negedge clk);
    md_flush = 1'b0;
    #1;
    checks++;
    if (hi_out !== 32'h11111111 || lo_out !== 32'h22222222 ||
        md_stall !== 1'b0 || div_req !== 1'b0) begin
      $display("[TB] FAIL flush_complete: hi=%h lo=%h stall=%b req=%b, expected 11111111 / 22222222 / 0 / 0",
               hi_out, lo_out, md_stall, div_req);
      errors++;
    end
    test_after_flush_divu("flush_complete");
  endtask

  task automatic test_watchdog();
    int i = 0;
    int stalls;
    never_complete = 1'b1;
    issue_op(MD_DIVU, 32'd1000, 32'd10);
    stalls = md_stall ? 1 : 0;
    while (md_err !== 1'b1 && i < 100) begin
      @(negedge clk);
      md_valid = 1'b0;
      #1;
      i++;
      if (md_stall) stalls++;
    end
    checks++;
    if (i !== 41 || stalls !== 41) begin
      $display("[TB] FAIL watchdog_timing: err_cycle=%0d stalls=%0d, expected 41 / 41", i, stalls);
      errors++;
    end
    @(negedge clk);
    #1;
    checks++;
    if (md_err !== 1'b0 || div_req !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd3) begin
      $display("[TB] FAIL watchdog_after: err=%b req=%b hi=%h lo=%h, expected 0 / 0 / 0 / 3",
               md_err, div_req, hi_out, lo_out);
      errors++;
    end
    never_complete = 1'b0;
  endtask

  task automatic test_async_reset();
    issue_op(MD_DIV, 32'hFFFFFF9C, 32'd7);
    repeat (5) @(negedge clk);
    md_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (md_stall !== 1'b0 || div_req !== 1'b0 || div_signed !== 1'b0 || md_err !== 1'b0 ||
        div_x !== 32'h0 || div_y !== 32'h0 || hi_out !== 32'h0 || lo_out !== 32'h0) begin
      $display("[TB] FAIL async_reset: stall=%b req=%b sgn=%b err=%b x=%h y=%h hi=%h lo=%h, expected all 0",
               md_stall, div_req, div_signed, md_err, div_x, div_y, hi_out, lo_out);
      errors++;
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (md_stall !== 1'b0 || div_req !== 1'b0) begin
      $display("[TB] FAIL post_reset_idle: stall=%b req=%b, expected 0 / 0", md_stall, div_req);
      errors++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mtx();
    test_mult(MD_MULT, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE);
    test_mult(MD_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE);
    test_mult_flush();
    test_divu();
    test_div_signed();
    test_flush_wait();
    test_flush_complete();
    test_watchdog();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
